// File: rtl/cccd_axil_pkg.sv
// cccd_axil_pkg: shared constants and the byte-strobe merge helper for the
// cccd AXI4-Lite register file.
package cccd_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = 4;

    // Merge the enabled byte lanes of data into old.
    function automatic logic [DATA_WIDTH-1:0] apply_strb(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] data,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = data[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cccd_axil_regs.sv
// cccd_axil_regs: AXI4-Lite slave holding NUM_REGS 32-bit control registers.
// One outstanding write (AW and W accepted in either order) and one
// outstanding read. Out-of-range accesses never touch register state.
// Optional feature macro: CCCD_AXIL_SLVERR_EN -- when defined, out-of-range
// accesses answer SLVERR; otherwise they answer OKAY.
module cccd_axil_regs
    import cccd_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [2:0]                   awprot,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [STRB_WIDTH-1:0]        wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_WIDTH-1:0]        araddr,
    input  logic [2:0]                   arprot,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]          wr_stb_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;

`ifdef CCCD_AXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    logic                  aw_held_q, aw_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic             aw_hs, w_hs, ar_hs, commit;
    logic             aw_in_range, ar_in_range;
    logic [IDX_W-1:0] ar_idx;

    // prot and the byte-offset address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

    assign awready = !aw_held_q && !bvalid_q;
    assign wready  = !w_held_q && !bvalid_q;
    assign arready = !rvalid_q;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = aw_held_q && w_held_q;

    assign ar_idx      = araddr[ADDR_WIDTH-1:2];
    assign aw_in_range = 32'(aw_idx_q) < 32'(NUM_REGS);
    assign ar_in_range = 32'(ar_idx) < 32'(NUM_REGS);

    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rresp    = rresp_q;
    assign rdata    = rdata_q;
    assign wr_stb_o = wr_stb_q;

    // Flatten the register array onto the fabric bus.
    always_comb begin
        reg_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_o[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
        end
    end

    // Write channel: capture AW/W independently, commit one edge after both are held.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_stb_d  = '0;
        regs_d    = regs_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end
        if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_in_range ? RESP_OKAY : OOR_RESP;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (aw_idx_q == IDX_W'(i)) begin
                    regs_d[i]   = apply_strb(regs_q[i], wdata_q, wstrb_q);
                    wr_stb_d[i] = 1'b1;
                end
            end
        end
    end

    // Read channel: register the response from pre-edge register state.
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;

        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_in_range ? RESP_OKAY : OOR_RESP;
            rdata_d  = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_idx == IDX_W'(i)) begin
                    rdata_d = regs_q[i];
                end
            end
        end
    end

    // State registers; reset discards any in-flight capture or response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            wr_stb_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            wr_stb_q  <= wr_stb_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cccd_axil_regs.sv
// tb_cccd_axil_regs: table-driven AXI4-Lite bench with response scoreboard
// plus hand sequences for ordering, stalls, read/commit collision and reset.
module tb_cccd_axil_regs;

    localparam int AW = 5;
    localparam int NR = 4;

`ifdef CCCD_AXIL_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic [AW-1:0]     awaddr = '0;
    logic [2:0]        awprot = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [AW-1:0]     araddr = '0;
    logic [2:0]        arprot = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [NR*32-1:0]  reg_o;
    logic [NR-1:0]     wr_stb_o;

    always #5 ACLK = ~ACLK;

    cccd_axil_regs #(.ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_o(reg_o), .wr_stb_o(wr_stb_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [31:0] model [NR];
    int          stb_cnt [NR];

    initial for (int i = 0; i < NR; i++) stb_cnt[i] = 0;

    always @(negedge ACLK) begin
        for (int i = 0; i < NR; i++) if (wr_stb_o[i]) stb_cnt[i]++;
    end

    typedef struct {
        bit          is_rd;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    function automatic int stb_sum();
        int s = 0;
        for (int i = 0; i < NR; i++) s += stb_cnt[i];
        return s;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[AW-1:2]);
        if (idx < NR) begin
            for (int k = 0; k < 4; k++) if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp_resp);
        bit aw_done, w_done, aw_now, w_now, got_b;
        logic [1:0] e;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        bq.push_back(exp_resp);
        aw_done = 0; w_done = 0;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            @(negedge ACLK);
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge ACLK); #1;
            if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
            if (w_now)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        if (!(aw_done && w_done)) begin
            awvalid = 1'b0; wvalid = 1'b0;
            timeout("write_handshake");
        end
        got_b = 0;
        for (int c = 0; c < 40 && !got_b; c++) begin
            @(negedge ACLK);
            if (bvalid) begin
                e = bq.pop_front();
                check("bresp", 128'(bresp), 128'(e));
                got_b = 1;
                @(posedge ACLK); #1;
            end
        end
        if (!got_b) begin
            timeout("bvalid");
            if (bq.size() > 0) void'(bq.pop_front());
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        bit hs, done, got_r;
        logic [33:0] e;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        rq.push_back({exp_r, exp_d});
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge ACLK);
            hs = arready;
            @(posedge ACLK); #1;
            if (hs) begin arvalid = 1'b0; done = 1; end
        end
        if (!done) begin arvalid = 1'b0; timeout("ar_handshake"); end
        got_r = 0;
        for (int c = 0; c < 40 && !got_r; c++) begin
            @(negedge ACLK);
            if (rvalid) begin
                e = rq.pop_front();
                check("rdata", 128'(rdata), 128'(e[31:0]));
                check("rresp", 128'(rresp), 128'(e[33:32]));
                got_r = 1;
                @(posedge ACLK); #1;
            end
        end
        if (!got_r) begin
            timeout("rvalid");
            if (rq.size() > 0) void'(rq.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, c1;
        bit bad;
        logic [31:0] first_rdata, old_val;

        vecs[0]  = '{0, 5'h00, 32'h1, 4'hF, 32'h0, 2'b00};
        vecs[1]  = '{0, 5'h04, 32'h2, 4'hF, 32'h0, 2'b00};
        vecs[2]  = '{0, 5'h08, 32'h3, 4'hF, 32'h0, 2'b00};
        vecs[3]  = '{0, 5'h0C, 32'h4, 4'hF, 32'h0, 2'b00};
        vecs[4]  = '{1, 5'h00, 32'h0, 4'h0, 32'h1, 2'b00};
        vecs[5]  = '{1, 5'h04, 32'h0, 4'h0, 32'h2, 2'b00};
        vecs[6]  = '{1, 5'h08, 32'h0, 4'h0, 32'h3, 2'b00};
        vecs[7]  = '{1, 5'h0C, 32'h0, 4'h0, 32'h4, 2'b00};
        vecs[8]  = '{0, 5'h04, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00};
        vecs[9]  = '{0, 5'h04, 32'hA5A5A5A5, 4'b0101, 32'h0, 2'b00};
        vecs[10] = '{1, 5'h04, 32'h0, 4'h0, 32'hFFA5FFA5, 2'b00};
        vecs[11] = '{0, 5'h10, 32'hDEADBEEF, 4'hF, 32'h0, OOR};
        vecs[12] = '{1, 5'h10, 32'h0, 4'h0, 32'h0, OOR};
        vecs[13] = '{0, 5'h0C, 32'hFFFFFFFF, 4'h0, 32'h0, 2'b00};
        vecs[14] = '{1, 5'h0C, 32'h0, 4'h0, 32'h4, 2'b00};
        for (int i = 0; i < NR; i++) model[i] = '0;

        // Reset state
        #12;
        check("rst_awready", 128'(awready), 128'(1));
        check("rst_wready",  128'(wready),  128'(1));
        check("rst_arready", 128'(arready), 128'(1));
        check("rst_bvalid",  128'(bvalid),  128'(0));
        check("rst_rvalid",  128'(rvalid),  128'(0));
        check("rst_resp",    128'({bresp, rresp}), 128'(0));
        check("rst_rdata",   128'(rdata),   128'(0));
        check("rst_reg_o",   128'(reg_o),   128'(0));
        check("rst_wr_stb",  128'(wr_stb_o), 128'(0));
        @(negedge ACLK); ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Table-driven vectors
        c1 = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 8) c1 = stb_cnt[1];
            if (vecs[i].is_rd) begin
                axi_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
            end else begin
                s0 = stb_sum();
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                s1 = stb_sum();
                check($sformatf("wr_stb_count_v%0d", i), 128'(s1 - s0),
                      128'((int'(vecs[i].addr[4:2]) < NR) ? 1 : 0));
            end
            if (i == 7) check("reg_o_after_4wr", reg_o, 128'h00000004_00000003_00000002_00000001);
            if (i == 9) check("stb1_twice", 128'(stb_cnt[1] - c1), 128'(2));
        end
        check("reg_o_after_table", reg_o, model_flat());

        // W before AW, with B held off
        bready = 1'b0;
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge ACLK);
        check("wfirst_wready", 128'(wready), 128'(1));
        @(posedge ACLK); #1; wvalid = 1'b0;
        check("wfirst_awready_still", 128'(awready), 128'(1));
        check("wfirst_wready_low", 128'(wready), 128'(0));
        repeat (3) @(posedge ACLK);
        #1;
        check("wfirst_no_commit", 128'(bvalid), 128'(0));
        awaddr = 5'h08; awvalid = 1'b1;
        @(posedge ACLK); #1; awvalid = 1'b0;
        check("wfirst_bvalid_at_aw_edge", 128'(bvalid), 128'(0));
        @(posedge ACLK); #1;
        check("wfirst_bvalid", 128'(bvalid), 128'(1));
        check("wfirst_stb", 128'(wr_stb_o), 128'(4'b0100));
        model[2] = 32'h12345678;
        check("wfirst_reg2", 128'(reg_o[95:64]), 128'(32'h12345678));

        // B stall: a second write must wait until B retires
        awaddr = 5'h00; wdata = 32'hCAFE0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            if (!bvalid || awready || wready) bad = 1;
        end
        check("bstall_hold", 128'(bad), 128'(0));
        bready = 1'b1;
        @(posedge ACLK); #1;
        check("bstall_retired", 128'(bvalid), 128'(0));
        check("bstall_awready_back", 128'(awready), 128'(1));
        check("bstall_reg0_untouched", 128'(reg_o[31:0]), 128'(model[0]));
        @(posedge ACLK); #1; awvalid = 1'b0; wvalid = 1'b0;
        check("bstall_no_early_commit", 128'(bvalid), 128'(0));
        @(posedge ACLK); #1;
        check("bstall_second_commit", 128'(bvalid), 128'(1));
        check("bstall_second_stb", 128'(wr_stb_o), 128'(4'b0001));
        model[0] = 32'hCAFE0000;
        @(posedge ACLK); #1;
        check("reg_o_after_stall", reg_o, model_flat());

        // R stall
        rready = 1'b0; araddr = 5'h08; arvalid = 1'b1;
        @(posedge ACLK); #1; arvalid = 1'b0;
        check("rstall_rvalid", 128'(rvalid), 128'(1));
        check("rstall_rdata", 128'(rdata), 128'(32'h12345678));
        first_rdata = rdata;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            if (!rvalid || arready || rdata !== first_rdata) bad = 1;
        end
        check("rstall_hold", 128'(bad), 128'(0));
        rready = 1'b1;
        @(posedge ACLK); #1;
        check("rstall_retired", 128'(rvalid), 128'(0));

        // Read and commit on the same register at the same edge
        old_val = model[1];
        bready = 1'b0;
        awaddr = 5'h04; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge ACLK); #1; awvalid = 1'b0; wvalid = 1'b0;
        araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
        @(posedge ACLK); #1; arvalid = 1'b0;
        check("collide_commit", 128'(bvalid), 128'(1));
        check("collide_rvalid", 128'(rvalid), 128'(1));
        check("collide_old_data", 128'(rdata), 128'(old_val));
        model[1] = 32'h11111111;
        bready = 1'b1; rready = 1'b1;
        @(posedge ACLK); #1;
        check("reg_o_after_collide", reg_o, model_flat());

        // Reset while a write is captured but not yet committed
        bready = 1'b0;
        awaddr = 5'h0C; wdata = 32'h77777777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge ACLK); #1; awvalid = 1'b0; wvalid = 1'b0;
        s0 = stb_sum();
        #2 ARESETN = 1'b0;
        #1;
        check("arst_awready", 128'(awready), 128'(1));
        check("arst_wready",  128'(wready),  128'(1));
        check("arst_bvalid",  128'(bvalid),  128'(0));
        check("arst_reg_o",   128'(reg_o),   128'(0));
        check("arst_stb",     128'(wr_stb_o), 128'(0));
        @(negedge ACLK); ARESETN = 1'b1;
        bready = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("arst_no_late_commit", 128'(bvalid), 128'(0));
        check("arst_reg_o_after", 128'(reg_o), 128'(0));
        check("arst_no_stb", 128'(stb_sum() - s0), 128'(0));
        for (int i = 0; i < NR; i++) model[i] = '0;
        axi_write(5'h0C, 32'h00C0FFEE, 4'hF, 2'b00);
        model_write(5'h0C, 32'h00C0FFEE, 4'hF);
        axi_read(5'h0C, 32'h00C0FFEE, 2'b00);
        check("reg_o_final", reg_o, model_flat());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
